// File: rtl/biriscv_issue_queue.sv
// biriscv_issue_queue: two-in / two-out in-order instruction buffer
// between decode and issue. Optional perf counter: BIRISCV_IQ_PERF_EN.
module biriscv_issue_queue #(
    parameter int DEPTH   = 8,
    parameter int DEPTH_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               in0_valid_i,
    input  logic [31:0]        in0_instr_i,
    input  logic [31:0]        in0_pc_i,
    input  logic [9:0]         in0_flags_i,
    output logic               in0_accept_o,
    input  logic               in1_valid_i,
    input  logic [31:0]        in1_instr_i,
    input  logic [31:0]        in1_pc_i,
    input  logic [9:0]         in1_flags_i,
    output logic               in1_accept_o,
    output logic               out0_valid_o,
    output logic [31:0]        out0_instr_o,
    output logic [31:0]        out0_pc_o,
    output logic [9:0]         out0_flags_o,
    input  logic               out0_accept_i,
    output logic               out1_valid_o,
    output logic [31:0]        out1_instr_o,
    output logic [31:0]        out1_pc_o,
    output logic [9:0]         out1_flags_o,
    input  logic               out1_accept_i,
    output logic [DEPTH_W:0]   count_o,
    output logic [31:0]        stall_cycles_o
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [9:0]  flags;
    } entry_t;

    localparam logic [DEPTH_W:0] CNT_M1 = (DEPTH_W+1)'(DEPTH - 1);
    localparam logic [DEPTH_W:0] CNT_M2 = (DEPTH_W+1)'(DEPTH - 2);
    localparam logic [DEPTH_W:0] CNT_1  = (DEPTH_W+1)'(1);

    entry_t               mem_q [DEPTH];
    logic [DEPTH_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W:0]     count_q, count_d;

    logic                 enq0, enq1, deq0, deq1;
    logic [DEPTH_W:0]     enq_n, deq_n;
    logic [DEPTH_W-1:0]   wr_idx1, rd_idx1;
    entry_t               in0_e, in1_e, head_e, next_e;

    assign in0_e = '{instr: in0_instr_i, pc: in0_pc_i, flags: in0_flags_i};
    assign in1_e = '{instr: in1_instr_i, pc: in1_pc_i, flags: in1_flags_i};

    // Accepts look only at current occupancy; dequeues give no credit.
    assign in0_accept_o = !flush_i && (count_q <= CNT_M1);
    assign in1_accept_o = !flush_i && (count_q <= CNT_M2);

    assign enq0 = in0_valid_i && in0_accept_o;
    assign enq1 = in1_valid_i && in1_accept_o && (enq0 || !in0_valid_i);

    assign out0_valid_o = (count_q != '0);
    assign out1_valid_o = (count_q > CNT_1);

    assign deq0 = out0_valid_o && out0_accept_i;
    assign deq1 = out1_valid_o && out1_accept_i && deq0;

    assign enq_n = {{DEPTH_W{1'b0}}, enq0} + {{DEPTH_W{1'b0}}, enq1};
    assign deq_n = {{DEPTH_W{1'b0}}, deq0} + {{DEPTH_W{1'b0}}, deq1};

    assign wr_idx1 = wr_ptr_q + DEPTH_W'(1);
    assign rd_idx1 = rd_ptr_q + DEPTH_W'(1);

    assign head_e = mem_q[rd_ptr_q];
    assign next_e = mem_q[rd_idx1];

    assign out0_instr_o = head_e.instr;
    assign out0_pc_o    = head_e.pc;
    assign out0_flags_o = head_e.flags;
    assign out1_instr_o = next_e.instr;
    assign out1_pc_o    = next_e.pc;
    assign out1_flags_o = next_e.flags;
    assign count_o      = count_q;

    // Next pointers/occupancy; flush drops all same-cycle traffic.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + deq_n[DEPTH_W-1:0];
            wr_ptr_d = wr_ptr_q + enq_n[DEPTH_W-1:0];
            count_d  = count_q + enq_n - deq_n;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; a lone slot-1 instruction lands at wr_ptr.
    always_ff @(posedge clk_i) begin
        if (enq0)
            mem_q[wr_ptr_q] <= in0_e;
        if (enq1)
            mem_q[enq0 ? wr_idx1 : wr_ptr_q] <= in1_e;
    end

`ifdef BIRISCV_IQ_PERF_EN
    logic [31:0] stall_q;
    logic        stall_inc;

    assign stall_inc = in0_valid_i && !in0_accept_o && !flush_i;

    // Saturating backpressure counter, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            stall_q <= '0;
        else if (stall_inc && (stall_q != 32'hFFFF_FFFF))
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: doc/biriscv_issue_queue.md
Name: biriscv_issue_queue

Overview:
- Dual-entry-per-cycle FIFO that buffers decoded instructions between the frontend decode outputs (fetch0/fetch1) and the issue stage.
- Decouples decode from issue stalls; preserves program order.
- Enqueues up to 2 per cycle and presents the oldest 2 entries to issue.
- Discarded wholesale on a pipeline flush (branch/exception).

Parameters:
- DEPTH, 8, number of entries; power of two, >= 4.
- DEPTH_W, 3, log2(DEPTH).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all entries (branch request / exception)
- in0_valid_i  in  1  older incoming instruction valid (fetch0_valid_o)
- in0_instr_i  in  32  instruction word
- in0_pc_i  in  32  PC
- in0_flags_i  in  10  {fault_fetch, fault_page, exec, lsu, branch, mul, div, csr, rd_valid, invalid}
- in0_accept_o  out  1  slot 0 accepted
- in1_valid_i / in1_instr_i / in1_pc_i / in1_flags_i  in  1/32/32/10  younger incoming instruction (fetch1_*)
- in1_accept_o  out  1  slot 1 accepted
- out0_valid_o / out0_instr_o / out0_pc_o / out0_flags_o  out  1/32/32/10  head entry
- out0_accept_i  in  1  issue consumed head
- out1_valid_o / out1_instr_o / out1_pc_o / out1_flags_o  out  1/32/32/10  head+1 entry
- out1_accept_i  in  1  issue consumed head+1
- count_o  out  DEPTH_W+1  current occupancy
- stall_cycles_o  out  32  backpressure cycle counter (see Optional Feature)

Behaviour:
- State: storage array[DEPTH]; rd_ptr and wr_ptr, DEPTH_W bits each, wrap modulo DEPTH; count, DEPTH_W+1 bits, range 0..DEPTH.
- Reset (rst_ni low, async): pointers = 0, count = 0, stall_cycles_o = 0. Storage is not reset.
- Output values at reset: out0_valid_o = out1_valid_o = 0; count_o = 0; in0_accept_o = in1_accept_o = 1.
- Accept (combinational, from pre-update count; no same-cycle dequeue credit):
  - in0_accept_o = !flush_i && count <= DEPTH-1
  - in1_accept_o = !flush_i && count <= DEPTH-2
- Enqueue:
  - enq0 = in0_valid_i && in0_accept_o.
  - enq1 = in1_valid_i && in1_accept_o && (enq0 || !in0_valid_i).
  - When both fire, slot 0 is written at wr_ptr and slot 1 at wr_ptr+1.
  - When only in1 is valid, it is written at wr_ptr.
  - wr_ptr advances by the number written.
  - Upstream must retain any unaccepted instruction; this block does not track partial pair acceptance.
- Dequeue:
  - out0_valid_o = count >= 1; out1_valid_o = count >= 2; no bypass, so enqueue-to-output latency is 1 cycle.
  - deq0 = out0_valid_o && out0_accept_i.
  - deq1 = out1_valid_o && out1_accept_i && deq0; out1_accept_i without out0_accept_i is ignored (in-order issue).
  - rd_ptr advances by deq0 + deq1.
- Occupancy: count_next = count + enq - deq, with simultaneous enqueue and dequeue both applied in the same cycle.
- Flush:
  - flush_i forces pointers and count to 0 next cycle.
  - The same cycle's dequeues and enqueues are dropped; accepts are low during flush.
  - Output valids still reflect current contents during the flush cycle; issue must itself ignore them.
- Full and empty:
  - At count = DEPTH both accepts are 0.
  - At count = DEPTH-1 only slot 0 is accepted.
  - At count = 0 both output valids are 0; out*_instr/pc/flags are don't-care when the matching valid is 0.
- Wrap: head+1 read index = rd_ptr+1 mod DEPTH; a pair written at wr_ptr = DEPTH-1 splits across index DEPTH-1 and index 0.
- Reset mid-operation: contents are lost immediately; first valid output appears 1 cycle after the first enqueue following release.

Optional Feature:
- Macro: BIRISCV_IQ_PERF_EN.
- Defined:
  - stall_cycles_o increments by 1 each cycle in which in0_valid_i && !in0_accept_o && !flush_i.
  - Saturates at 32'hFFFFFFFF; cleared only by reset.
- Undefined: stall_cycles_o is tied to 0 and no counter flops exist; the port remains present.

Test Plan:
- Reset release, then in0/in1 valid with PC 0x1000/0x1004 -> next cycle out0_pc_o = 0x1000, out1_pc_o = 0x1004, both valid, count_o = 2.
- Fill with DEPTH = 8 and no out accepts: after 4 pair enqueues count_o = 8 and in0_accept_o = 0; with count_o = 7, in0_accept_o = 1 and in1_accept_o = 0.
- out1_accept_i = 1 while out0_accept_i = 0 -> nothing dequeued, count unchanged, head PC unchanged.
- Wrap: 7 single enqueues, 7 dequeues, then pair 0x2000/0x2004 -> stored at indices 7 and 0; outputs in order 0x2000 then 0x2004.
- flush_i with count = 5 and in0_valid_i = 1 in the same cycle -> accepts 0 that cycle, count_o = 0 next cycle, both out valids 0.
- BIRISCV_IQ_PERF_EN defined: hold the queue full with in0_valid_i = 1 for 10 cycles -> stall_cycles_o = 10. Macro undefined -> stall_cycles_o stays 0.
